// File: rtl/vd_acs_scheduler.sv
// ACS sequencer for the rate-1/2 Viterbi decoder: walks butterfly groups through the
// shared ACS units per symbol and drives metric bank, survivor column and traceback launch.
//
// state | meaning
// IDLE  | decoding disabled, waiting for Active
// INIT  | writing initial path metrics, one group per cycle
// WAIT  | ready for the next code symbol
// ACS   | issuing metric reads, one group per cycle
// DRAIN | waiting for the ACS pipeline to retire the last write
module vd_acs_scheduler #(
    parameter int K         = 9,
    parameter int BFLY_LOG2 = 2,
    parameter int ACS_LAT   = 2,
    parameter int TB_DEPTH  = 64,
    localparam int WD_GRP   = K - 2 - BFLY_LOG2,
    localparam int GROUPS   = 1 << WD_GRP,
    localparam int WD_COL   = $clog2(TB_DEPTH)
) (
    input  logic              CLOCK,
    input  logic              Reset,
    input  logic              Active,
    input  logic              SymValid,
    input  logic              NormReq,
    output logic              SymAccept,
    output logic              RdEn,
    output logic [WD_GRP-1:0] RdGrp,
    output logic              RdBank,
    output logic              WrEn,
    output logic [WD_GRP-1:0] WrGrp,
    output logic              WrBank,
    output logic              InitEn,
    output logic              NormEn,
    output logic              SurvWrEn,
    output logic [WD_COL-1:0] SurvCol,
    output logic              TbStart,
    output logic [WD_COL-1:0] TbCol,
    output logic              Busy,
    output logic              Overrun
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_ACS, S_DRAIN} state_t;

    state_t              state, state_nx;
    logic [WD_GRP-1:0]   cnt;
    logic [ACS_LAT-1:0]  pipe_en;
    logic [WD_GRP-1:0]   pipe_grp [ACS_LAT];
    logic [WD_COL:0]     fill;
    logic                rd_bank;
    logic                norm_pend;
    logic                norm_en;
    logic                overrun_q;
    logic                tb_start;
    logic [WD_COL-1:0]   tb_col;
    logic [WD_COL-1:0]   surv_col;
    logic                accept;
    logic                done_sym;
    logic                last_grp;
    logic                last_wr;
    logic                wr_pipe;

    assign last_grp = (cnt == WD_GRP'(GROUPS - 1));
    assign wr_pipe  = pipe_en[ACS_LAT-1];
    assign last_wr  = wr_pipe && (pipe_grp[ACS_LAT-1] == WD_GRP'(GROUPS - 1));

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        done_sym = 1'b0;
        case (state)
            S_IDLE:  if (Active) state_nx = S_INIT;
            S_INIT:  if (last_grp) state_nx = Active ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!Active) begin
                    state_nx = S_IDLE;
                end else if (SymValid) begin
                    accept   = 1'b1;
                    state_nx = S_ACS;
                end
            end
            S_ACS:   if (last_grp) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (last_wr) begin
                    done_sym = 1'b1;
                    state_nx = Active ? S_WAIT : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pipe_en   <= '0;
            for (int i = 0; i < ACS_LAT; i++) pipe_grp[i] <= '0;
            fill      <= '0;
            rd_bank   <= 1'b0;
            norm_pend <= 1'b0;
            norm_en   <= 1'b0;
            overrun_q <= 1'b0;
            tb_start  <= 1'b0;
            tb_col    <= '0;
            surv_col  <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_INIT || state == S_ACS) && state_nx == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            pipe_en[0]  <= (state == S_ACS);
            pipe_grp[0] <= cnt;
            for (int i = 1; i < ACS_LAT; i++) begin
                pipe_en[i]  <= pipe_en[i-1];
                pipe_grp[i] <= pipe_grp[i-1];
            end

            if (state == S_IDLE && state_nx == S_INIT) begin
                overrun_q <= 1'b0;
                fill      <= '0;
                surv_col  <= '0;
                rd_bank   <= 1'b0;
            end else if (Busy && SymValid) begin
                overrun_q <= 1'b1;
            end

            // A request in the accept cycle is folded into the symbol being taken.
            if (accept) begin
                norm_en   <= norm_pend | NormReq;
                norm_pend <= 1'b0;
            end else begin
                norm_pend <= norm_pend | NormReq;
                if (state == S_ACS && last_grp) norm_en <= 1'b0;
            end

            tb_start <= 1'b0;
            if (done_sym) begin
                rd_bank  <= ~rd_bank;
                surv_col <= surv_col + 1'b1;
                tb_col   <= surv_col;
                tb_start <= (fill >= (WD_COL+1)'(TB_DEPTH - 1));
                if (fill != (WD_COL+1)'(TB_DEPTH)) fill <= fill + 1'b1;
            end
        end
    end

    assign SymAccept = accept;
    assign RdEn      = (state == S_ACS);
    assign RdGrp     = RdEn ? cnt : '0;
    assign RdBank    = rd_bank;
    assign InitEn    = (state == S_INIT);
    assign WrEn      = InitEn | wr_pipe;
    assign WrGrp     = InitEn ? cnt : (wr_pipe ? pipe_grp[ACS_LAT-1] : '0);
    assign SurvWrEn  = ~InitEn & wr_pipe;
    assign WrBank    = SurvWrEn & ~rd_bank;
    assign NormEn    = norm_en;
    assign SurvCol   = surv_col;
    assign TbStart   = tb_start;
    assign TbCol     = tb_col;
    assign Busy      = (state == S_INIT) || (state == S_ACS) || (state == S_DRAIN);
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_vd_acs_scheduler.sv
// Randomized bench for vd_acs_scheduler, compared each cycle against a timestamp-based
// model of the symbol timeline (init start, accept time, bank/column/fill bookkeeping).
module tb_vd_acs_scheduler;
    localparam int G     = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic       CLOCK = 1'b0;
    logic       Reset, Active, SymValid, NormReq;
    logic       SymAccept, RdEn, RdBank, WrEn, WrBank, InitEn, NormEn, SurvWrEn;
    logic       TbStart, Busy, Overrun;
    logic [4:0] RdGrp, WrGrp;
    logic [5:0] SurvCol, TbCol;

    vd_acs_scheduler dut (
        .CLOCK(CLOCK), .Reset(Reset), .Active(Active), .SymValid(SymValid), .NormReq(NormReq),
        .SymAccept(SymAccept), .RdEn(RdEn), .RdGrp(RdGrp), .RdBank(RdBank),
        .WrEn(WrEn), .WrGrp(WrGrp), .WrBank(WrBank), .InitEn(InitEn), .NormEn(NormEn),
        .SurvWrEn(SurvWrEn), .SurvCol(SurvCol), .TbStart(TbStart), .TbCol(TbCol),
        .Busy(Busy), .Overrun(Overrun)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int tb_seen = 0, acc_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // reference model state
    bit m_idle = 1, armed = 0, acc_valid = 0;
    bit m_ovr = 0, m_bank = 0, m_tb = 0, m_npend = 0, m_snorm = 0;
    int init_t0 = -1000, acc_t = -1000, m_col = 0, m_fill = 0, m_tbcol = 0;

    always @(negedge CLOCK) begin
        bit in_init, in_rd, in_wr, busy, waiting, acc, tb_nx;
        int wgrp;
        in_init = !m_idle && cyc >= init_t0 && cyc < init_t0 + G;
        in_rd   = acc_valid && cyc >= acc_t + 1 && cyc <= acc_t + G;
        in_wr   = acc_valid && cyc >= acc_t + 1 + LAT && cyc <= acc_t + G + LAT;
        busy    = in_init || (acc_valid && cyc >= acc_t + 1 && cyc <= acc_t + G + LAT);
        waiting = !m_idle && !busy;
        acc     = waiting && Active && SymValid;
        wgrp    = in_init ? cyc - init_t0 : (in_wr ? cyc - acc_t - 1 - LAT : 0);

        if (armed) begin
            check("SymAccept", SymAccept, acc);
            check("Busy", Busy, busy);
            check("RdEn", RdEn, in_rd);
            check("RdGrp", RdGrp, in_rd ? cyc - acc_t - 1 : 0);
            check("RdBank", RdBank, m_bank);
            check("WrEn", WrEn, in_init || in_wr);
            check("WrGrp", WrGrp, wgrp);
            check("WrBank", WrBank, in_wr ? !m_bank : 0);
            check("InitEn", InitEn, in_init);
            check("NormEn", NormEn, in_rd && m_snorm);
            check("SurvWrEn", SurvWrEn, in_wr);
            check("SurvCol", SurvCol, m_col);
            check("TbStart", TbStart, m_tb);
            check("TbCol", TbCol, m_tbcol);
            check("Overrun", Overrun, m_ovr);
            if (TbStart === 1'b1) tb_seen++;
            if (SymAccept === 1'b1) acc_seen++;
        end

        if (!Reset) begin
            armed = 1; m_idle = 1; acc_valid = 0; m_ovr = 0; m_bank = 0; m_tb = 0;
            m_npend = 0; m_snorm = 0; m_col = 0; m_fill = 0; m_tbcol = 0;
        end else begin
            tb_nx = 0;
            if (busy && SymValid) m_ovr = 1;
            if (acc) begin
                acc_t = cyc; acc_valid = 1;
                m_snorm = m_npend || NormReq; m_npend = 0;
            end else if (NormReq) begin
                m_npend = 1;
            end
            if (m_idle && Active) begin
                m_idle = 0; init_t0 = cyc + 1; acc_valid = 0;
                m_ovr = 0; m_fill = 0; m_col = 0; m_bank = 0;
            end else if (in_init && cyc == init_t0 + G - 1 && !Active) begin
                m_idle = 1;
            end else if (waiting && !Active) begin
                m_idle = 1;
            end
            if (acc_valid && cyc == acc_t + G + LAT) begin
                m_bank  = !m_bank;
                m_tbcol = m_col;
                tb_nx   = (m_fill + 1 >= DEPTH);
                m_col   = (m_col + 1) % DEPTH;
                if (m_fill < DEPTH) m_fill++;
                if (!Active) m_idle = 1;
            end
            m_tb = tb_nx;
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    initial begin
        Reset = 0; Active = 0; SymValid = 0; NormReq = 0;
        tick(2);
        Reset = 1; Active = 1;
        tick(33);

        // back-to-back symbols at minimum spacing, sparse normalization requests
        for (int i = 0; i < 70; i++) begin
            SymValid = 1; NormReq = ($urandom_range(0, 9) == 0);
            tick(1);
            SymValid = 0;
            for (int j = 0; j < 34; j++) begin
                NormReq = ($urandom_range(0, 39) == 0);
                tick(1);
            end
        end
        NormReq = 0;
        tick(1);
        check("tb_pulses", tb_seen, 7);
        check("accepts", acc_seen, 70);
        check("no_overrun", Overrun, 0);

        // symbol during ACS is dropped and flagged
        SymValid = 1; tick(1); SymValid = 0;
        tick(10);
        SymValid = 1; tick(1); SymValid = 0;
        tick(40);
        check("overrun_held", Overrun, 1);

        for (int i = 0; i < 400; i++) begin
            SymValid = ($urandom_range(0, 14) == 0);
            NormReq  = ($urandom_range(0, 24) == 0);
            tick(1);
        end
        SymValid = 0; NormReq = 0;
        tick(40);

        // Active drop mid-ACS, then re-init, then reset mid-ACS
        SymValid = 1; tick(1); SymValid = 0;
        tick(5);
        Active = 0;
        tick(40);
        check("idle_after_drop", Busy, 0);
        Active = 1;
        tick(33);
        check("overrun_cleared", Overrun, 0);
        SymValid = 1; tick(1); SymValid = 0;
        tick(5);
        Reset = 0; tick(1); Reset = 1;
        tick(40);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) Active = !Active;
            Reset    = ($urandom_range(0, 999) != 0);
            SymValid = ($urandom_range(0, 11) == 0);
            NormReq  = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        Reset = 1; SymValid = 0; NormReq = 0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
